// File: rtl/pong_game_ctrl_if.sv
// Per-frame control/status bundle between the Pong game sequencer and its
// neighbours (paddle movement logic upstream, pixel colouring downstream).
interface pong_game_ctrl_if;
  logic        frame_tick;
  logic        start;
  logic [9:0]  ypos1;
  logic [9:0]  ypos2;
  logic [9:0]  ball_x;
  logic [9:0]  ball_y;
  logic [15:0] score;
  logic [2:0]  state;
  logic        game_over;
  logic        point_pulse;

  modport master (
    output frame_tick, start, ypos1, ypos2,
    input  ball_x, ball_y, score, state, game_over, point_pulse
  );

  modport slave (
    input  frame_tick, start, ypos1, ypos2,
    output ball_x, ball_y, score, state, game_over, point_pulse
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve timing, ball motion, wall/paddle collisions, scoring, win detection.
// Optional macro PONG_SPEEDUP_EN: each paddle hit speeds the ball up by 1 pixel/frame (max 6).
module pong_game_ctrl #(
  parameter int BALL_SPEED  = 2,
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 60,
  parameter int FIELD_TOP   = 34,
  parameter int FIELD_BOT   = 516,
  parameter int FIELD_LEFT  = 144,
  parameter int FIELD_RIGHT = 783,
  parameter int BALL_HALF   = 10,
  parameter int PAD_HALF    = 30,
  parameter int LPAD_X      = 165,
  parameter int RPAD_X      = 762
) (
  input logic             clk,
  input logic             rst,
  pong_game_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    POINT     = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  localparam int              CW        = $clog2(SERVE_DELAY + 1);
  localparam logic [9:0]      CX        = 10'((FIELD_LEFT + FIELD_RIGHT) / 2);
  localparam logic [9:0]      CY        = 10'((FIELD_TOP + FIELD_BOT) / 2);
  localparam logic [9:0]      TOP_Y     = 10'(FIELD_TOP + BALL_HALF);
  localparam logic [9:0]      BOT_Y     = 10'(FIELD_BOT - BALL_HALF);
  localparam logic [9:0]      LBOUNCE_X = 10'(LPAD_X + BALL_HALF + 1);
  localparam logic [9:0]      RBOUNCE_X = 10'(RPAD_X - BALL_HALF - 1);
  localparam logic signed [10:0] S_BH    = 11'(BALL_HALF);
  localparam logic signed [10:0] S_TOP   = 11'(FIELD_TOP);
  localparam logic signed [10:0] S_BOT   = 11'(FIELD_BOT);
  localparam logic signed [10:0] S_LEFT  = 11'(FIELD_LEFT);
  localparam logic signed [10:0] S_RIGHT = 11'(FIELD_RIGHT);
  localparam logic signed [10:0] S_LPAD  = 11'(LPAD_X);
  localparam logic signed [10:0] S_RPAD  = 11'(RPAD_X);
  localparam logic signed [10:0] S_LREAR = 11'(LPAD_X - 10);
  localparam logic signed [10:0] S_RREAR = 11'(RPAD_X + 10);
  localparam logic signed [10:0] S_REACH = 11'(PAD_HALF + BALL_HALF);
  localparam logic [7:0]      WIN       = 8'(WIN_SCORE);

  state_t         st, st_n;
  logic [9:0]     bx, bx_n, by, by_n;
  logic           vx_neg, vx_neg_n, vy_neg, vy_neg_n;
  logic [7:0]     p1, p1_n, p2, p2_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           pp, pp_n;
  logic signed [10:0] step;

`ifdef PONG_SPEEDUP_EN
  localparam logic [2:0] SPD_INIT = 3'(BALL_SPEED);
  localparam logic [2:0] SPD_MAX  = 3'd6;
  logic [2:0] spd, spd_n;
  assign step = signed'({8'b0, spd});
`else
  assign step = 11'(BALL_SPEED);
`endif

  logic signed [10:0] sx, sy, nx, ny, d1, d2, a1, a2;
  logic lhit, rhit, lmiss, rmiss, up_wall, dn_wall;

  // Geometry of the candidate move; all signed so edge maths cannot wrap.
  always_comb begin
    sx      = signed'({1'b0, bx});
    sy      = signed'({1'b0, by});
    nx      = vx_neg ? sx - step : sx + step;
    ny      = vy_neg ? sy - step : sy + step;
    d1      = ny - signed'({1'b0, bus.ypos1});
    d2      = ny - signed'({1'b0, bus.ypos2});
    a1      = d1[10] ? -d1 : d1;
    a2      = d2[10] ? -d2 : d2;
    up_wall = vy_neg && (ny - S_BH <= S_TOP);
    dn_wall = !vy_neg && (ny + S_BH >= S_BOT);
    lhit    = vx_neg && (nx - S_BH <= S_LPAD) && (sx - S_BH > S_LREAR) && (a1 <= S_REACH);
    rhit    = !vx_neg && (nx + S_BH >= S_RPAD) && (sx + S_BH < S_RREAR) && (a2 <= S_REACH);
    lmiss   = vx_neg && (nx - S_BH <= S_LEFT);
    rmiss   = !vx_neg && (nx + S_BH >= S_RIGHT);
  end

  always_comb begin
    st_n     = st;
    bx_n     = bx;
    by_n     = by;
    vx_neg_n = vx_neg;
    vy_neg_n = vy_neg;
    p1_n     = p1;
    p2_n     = p2;
    cnt_n    = cnt;
    pp_n     = 1'b0;
`ifdef PONG_SPEEDUP_EN
    spd_n    = spd;
`endif
    unique case (st)
      IDLE: begin
        bx_n = CX;
        by_n = CY;
        if (bus.start) begin
          st_n     = SERVE;
          p1_n     = '0;
          p2_n     = '0;
          vx_neg_n = 1'b0;
          cnt_n    = '0;
        end
      end
      SERVE: begin
        bx_n = CX;
        by_n = CY;
        // Launch on the tick that would bring the count up to SERVE_DELAY.
        if (bus.frame_tick) begin
          if (cnt == CW'(SERVE_DELAY - 1)) begin
            st_n  = PLAY;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      PLAY: begin
        if (bus.frame_tick) begin
          if (up_wall) begin
            by_n     = TOP_Y;
            vy_neg_n = 1'b0;
          end else if (dn_wall) begin
            by_n     = BOT_Y;
            vy_neg_n = 1'b1;
          end else begin
            by_n = ny[9:0];
          end
          if (lhit) begin
            bx_n     = LBOUNCE_X;
            vx_neg_n = 1'b0;
`ifdef PONG_SPEEDUP_EN
            spd_n    = (spd < SPD_MAX) ? spd + 3'd1 : SPD_MAX;
`endif
          end else if (rhit) begin
            bx_n     = RBOUNCE_X;
            vx_neg_n = 1'b1;
`ifdef PONG_SPEEDUP_EN
            spd_n    = (spd < SPD_MAX) ? spd + 3'd1 : SPD_MAX;
`endif
          end else begin
            bx_n = nx[9:0];
            // vx_neg doubles as the serve direction and so also names the scorer.
            if (lmiss) begin
              p2_n     = (p2 == 8'hFF) ? p2 : p2 + 8'd1;
              pp_n     = 1'b1;
              vx_neg_n = 1'b1;
              st_n     = POINT;
`ifdef PONG_SPEEDUP_EN
              spd_n    = SPD_INIT;
`endif
            end else if (rmiss) begin
              p1_n     = (p1 == 8'hFF) ? p1 : p1 + 8'd1;
              pp_n     = 1'b1;
              vx_neg_n = 1'b0;
              st_n     = POINT;
`ifdef PONG_SPEEDUP_EN
              spd_n    = SPD_INIT;
`endif
            end
          end
        end
      end
      POINT: begin
        if ((vx_neg ? p2 : p1) == WIN) begin
          st_n = GAME_OVER;
        end else begin
          st_n = SERVE;
          bx_n = CX;
          by_n = CY;
`ifdef PONG_SPEEDUP_EN
          spd_n = SPD_INIT;
`endif
        end
      end
      GAME_OVER: begin
        if (bus.start) begin
          st_n = IDLE;
          bx_n = CX;
          by_n = CY;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      bx     <= CX;
      by     <= CY;
      vx_neg <= 1'b0;
      vy_neg <= 1'b0;
      p1     <= '0;
      p2     <= '0;
      cnt    <= '0;
      pp     <= 1'b0;
`ifdef PONG_SPEEDUP_EN
      spd    <= SPD_INIT;
`endif
    end else begin
      st     <= st_n;
      bx     <= bx_n;
      by     <= by_n;
      vx_neg <= vx_neg_n;
      vy_neg <= vy_neg_n;
      p1     <= p1_n;
      p2     <= p2_n;
      cnt    <= cnt_n;
      pp     <= pp_n;
`ifdef PONG_SPEEDUP_EN
      spd    <= spd_n;
`endif
    end
  end

  assign bus.ball_x      = bx;
  assign bus.ball_y      = by;
  assign bus.score       = {p1, p2};
  assign bus.state       = st;
  assign bus.game_over   = (st == GAME_OVER);
  assign bus.point_pulse = pp;

endmodule
